// File: rtl/tetris_score_level_ctrl.sv
// Score, line and level bookkeeping for the Tetris datapath. It also produces the
// level-dependent fall tick and a sequentially converted BCD copy of the score.
module tetris_score_level_ctrl #(
  parameter int SCORE_W         = 10,
  parameter int SCORE_MAX       = 999,
  parameter int PTS_1           = 1,
  parameter int PTS_2           = 10,
  parameter int PTS_3           = 66,
  parameter int PTS_4           = 100,
  parameter int LINES_W         = 8,
  parameter int LINES_PER_LEVEL = 10,
  parameter int LEVEL_MAX       = 9,
  parameter int TICK_BASE       = 25_000_000,
  parameter int TICK_STEP       = 2_000_000,
  parameter int TICK_MIN        = 2_500_000,
  parameter int BCD_DIGITS      = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    restart,
  input  logic                    pause,
  input  logic                    clr_valid,
  input  logic [2:0]              clr_count,
  output logic [SCORE_W-1:0]      score,
  output logic [LINES_W-1:0]      lines,
  output logic [3:0]              level,
  output logic                    target_reached,
  output logic                    falling_update,
  output logic [4*BCD_DIGITS-1:0] score_bcd,
  output logic                    bcd_valid
);

  localparam int LVL_W = $clog2(LINES_PER_LEVEL + 4);
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam int TMR_W = $clog2(TICK_BASE + 1);
  localparam int BCD_W = 4 * BCD_DIGITS;

  localparam logic [SCORE_W:0]   PTS1_W = (SCORE_W+1)'(PTS_1);
  localparam logic [SCORE_W:0]   PTS2_W = (SCORE_W+1)'(PTS_2);
  localparam logic [SCORE_W:0]   PTS3_W = (SCORE_W+1)'(PTS_3);
  localparam logic [SCORE_W:0]   PTS4_W = (SCORE_W+1)'(PTS_4);
  localparam logic [SCORE_W:0]   MAX_X  = (SCORE_W+1)'(SCORE_MAX);
  localparam logic [SCORE_W-1:0] MAX_S  = SCORE_W'(SCORE_MAX);
  localparam logic [LVL_W-1:0]   LPL_W  = LVL_W'(LINES_PER_LEVEL);
  localparam logic [3:0]         LVL_MX = 4'(LEVEL_MAX);

  // ---------------------------------------------------------------------------
  // Line-clear event decode. clr_valid is a one-cycle event with no ready/backpressure:
  // it is consumed on the edge where it is high, or it is dropped when the count is
  // invalid or the target has been reached.
  // ---------------------------------------------------------------------------
  logic                 accept;
  logic                 score_chg;
  logic [SCORE_W:0]     pts;
  logic [SCORE_W:0]     score_sum;
  logic [SCORE_W-1:0]   score_nx;
  logic [LINES_W:0]     lines_sum;
  logic [LINES_W-1:0]   lines_nx;
  logic [LVL_W-1:0]     lvl_lines;
  logic [LVL_W-1:0]     lvl_sum;
  logic                 lvl_step;

  always_comb begin
    pts = '0;
    case (clr_count)
      3'd1:    pts = PTS1_W;
      3'd2:    pts = PTS2_W;
      3'd3:    pts = PTS3_W;
      3'd4:    pts = PTS4_W;
      default: pts = '0;
    endcase
    accept    = clr_valid && !target_reached && (clr_count >= 3'd1) && (clr_count <= 3'd4);
    score_sum = {1'b0, score} + pts;
    score_nx  = (score_sum >= MAX_X) ? MAX_S : score_sum[SCORE_W-1:0];
    score_chg = accept && (score_nx != score);
    lines_sum = {1'b0, lines} + (LINES_W+1)'(clr_count);
    lines_nx  = lines_sum[LINES_W] ? '1 : lines_sum[LINES_W-1:0];
    lvl_sum   = lvl_lines + LVL_W'(clr_count);
    lvl_step  = (lvl_sum >= LPL_W);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      score          <= '0;
      lines          <= '0;
      level          <= '0;
      lvl_lines      <= '0;
      target_reached <= 1'b0;
    end else if (restart) begin
      score          <= '0;
      lines          <= '0;
      level          <= '0;
      lvl_lines      <= '0;
      target_reached <= 1'b0;
    end else if (accept) begin
      score <= score_nx;
      lines <= lines_nx;
      // Level-up keeps the remainder; lvl_lines keeps wrapping once level is capped.
      if (lvl_step) begin
        lvl_lines <= lvl_sum - LPL_W;
        if (level != LVL_MX) level <= level + 4'd1;
      end else begin
        lvl_lines <= lvl_sum;
      end
      if (score_nx == MAX_S) target_reached <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Fall timer
  // ---------------------------------------------------------------------------
  function automatic logic [TMR_W-1:0] period_m1_f(input logic [3:0] lv);
    int p;
    p = TICK_BASE - int'(lv) * TICK_STEP;
    if (p < TICK_MIN) p = TICK_MIN;
    return TMR_W'(p - 1);
  endfunction

  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] period_m1;
  logic             tick_hit;

  // ">=" rather than "==" so a level-up that shortens the period below the current
  // count fires immediately instead of wrapping the counter.
  assign period_m1      = period_m1_f(level);
  assign tick_hit       = (tmr >= period_m1);
  assign falling_update = !pause && !restart && tick_hit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmr <= '0;
    end else if (restart) begin
      tmr <= '0;
    end else if (!pause) begin
      tmr <= tick_hit ? '0 : tmr + TMR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // BCD converter: shift-and-add-3, one bit per cycle
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    BCD_IDLE  = 2'd0,
    BCD_SHIFT = 2'd1,
    BCD_DONE  = 2'd2
  } bcd_state_t;

  bcd_state_t         bcd_state;
  bcd_state_t         bcd_state_nx;
  logic [CNT_W-1:0]   sh_cnt;
  logic [SCORE_W-1:0] sh_bin;
  logic [BCD_W-1:0]   sh_bcd;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   bcd_step;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) bcd_state <= BCD_IDLE;
    else       bcd_state <= bcd_state_nx;
  end

  always_comb begin
    bcd_state_nx = bcd_state;
    case (bcd_state)
      BCD_SHIFT: if (sh_cnt == CNT_W'(SCORE_W - 1)) bcd_state_nx = BCD_DONE;
      BCD_DONE:  bcd_state_nx = BCD_IDLE;
      default:   bcd_state_nx = bcd_state;
    endcase
    // A new score aborts whatever is in flight; restart beats everything.
    if (score_chg) bcd_state_nx = BCD_SHIFT;
    if (restart)   bcd_state_nx = BCD_IDLE;
  end

  always_comb begin
    adj = sh_bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    bcd_step = {adj[BCD_W-2:0], sh_bin[SCORE_W-1]};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_cnt    <= '0;
      sh_bin    <= '0;
      sh_bcd    <= '0;
      score_bcd <= '0;
      bcd_valid <= 1'b1;
    end else if (restart) begin
      sh_cnt    <= '0;
      sh_bin    <= '0;
      sh_bcd    <= '0;
      score_bcd <= '0;
      bcd_valid <= 1'b1;
    end else if (score_chg) begin
      sh_cnt    <= '0;
      sh_bin    <= score_nx;
      sh_bcd    <= '0;
      bcd_valid <= 1'b0;
    end else begin
      case (bcd_state)
        BCD_SHIFT: begin
          sh_bcd <= bcd_step;
          sh_bin <= sh_bin << 1;
          sh_cnt <= sh_cnt + CNT_W'(1);
        end
        BCD_DONE: begin
          score_bcd <= sh_bcd;
          bcd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/tetris_score_level_ctrl.md
# tetris_score_level_ctrl

Parametrised score, line and level controller for the Tetris datapath, replacing the hard-coded score register in the top-level wrapper. It consumes one line-clear event per locked piece from the bitmap, keeps a saturating score, line and level count, and generates the level-dependent `falling_update` tick for the block controller. It also produces a sequentially converted BCD score for the seven-segment display.

## Interface
- `SCORE_W`, 10, score register width.
- `SCORE_MAX`, 999, score saturation and target value; must be < 2^SCORE_W.
- `PTS_1` / `PTS_2` / `PTS_3` / `PTS_4`, 1 / 10 / 66 / 100, points for clearing 1/2/3/4 lines.
- `LINES_W`, 8, total-lines counter width.
- `LINES_PER_LEVEL`, 10, lines per level step; must be >= 4.
- `LEVEL_MAX`, 9, highest level; level width is 4 bits.
- `TICK_BASE`, 25_000_000, fall period in clk cycles at level 0.
- `TICK_STEP`, 2_000_000, period reduction per level.
- `TICK_MIN`, 2_500_000, floor on the fall period.
- `BCD_DIGITS`, 4, number of BCD digits; must satisfy 10^BCD_DIGITS > SCORE_MAX.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset; asynchronous assert, active-low.
- `restart`  in  1  synchronous clear of all state, one-cycle pulse.
- `pause`  in  1  level-sensitive; freezes the fall timer.
- `clr_valid`  in  1  one-cycle line-clear event.
- `clr_count`  in  3  lines cleared, 0..4; sampled when `clr_valid`=1.
- `score`  out  SCORE_W  current score.
- `lines`  out  LINES_W  total lines cleared, saturating.
- `level`  out  4  current level.
- `target_reached`  out  1  sticky; set when score reaches SCORE_MAX.
- `falling_update`  out  1  one-cycle fall tick.
- `score_bcd`  out  4*BCD_DIGITS  BCD score; digit 0 in the LSBs.
- `bcd_valid`  out  1  high when `score_bcd` equals `score`.

## Operation
- **Reset values:** rstn=0 or restart=1 forces all outputs to 0, except `bcd_valid`, which is forced to 1.
- **Points:** `clr_valid` with count 1..4 adds PTS_n. Count 0 or 5..7 is ignored entirely: no score, line or level change.
- **Score:** `score <= min(score + PTS_n, SCORE_MAX)`. Compute the add at SCORE_W+1 bits before saturating, so the sum never wraps.
- **Target:** `target_reached` sets in the same cycle that score becomes SCORE_MAX. While it is set, all `clr_valid` events are ignored and score, lines and level are frozen.
- **Lines:** `lines += clr_count`, saturating at 2^LINES_W-1.
- **Level:**
  - An internal `lvl_lines` counter accumulates cleared lines.
  - When `lvl_lines + clr_count >= LINES_PER_LEVEL`, level increments (capped at LEVEL_MAX) and `lvl_lines` keeps the remainder.
  - At most one level step occurs per event.
  - At LEVEL_MAX, `lvl_lines` continues to wrap but level stays.
- **Fall timer:**
  - Counter runs from 0 to P-1, where P = max(TICK_BASE - level*TICK_STEP, TICK_MIN).
  - At count P-1, `falling_update`=1 for one cycle and the counter returns to 0.
  - `pause`=1 holds the counter and forces `falling_update`=0.
  - A level change does not reset the counter. If count >= new P-1, the tick fires on the next cycle and the counter restarts.
- **BCD converter:** FSM with states IDLE, SHIFT and DONE.
  - Any score change latches the new score and enters SHIFT, and `bcd_valid` drops.
  - SHIFT runs SCORE_W cycles of shift-and-add-3 (add 3 to each digit >= 5 before each shift).
  - DONE updates `score_bcd`, raises `bcd_valid` and returns to IDLE.
  - `score_bcd` keeps its old value until DONE.
  - A score change during SHIFT aborts the conversion and restarts it with the new value.

## Timing
- **Event latency:** `clr_valid` sampled at edge N → `score`, `lines`, `level` and `target_reached` are updated after edge N.
- **BCD latency:** `bcd_valid`=0 from the cycle after the score change; `bcd_valid`=1 and new `score_bcd` appear SCORE_W+1 cycles after the score update.
- **Fall period:** `falling_update` pulses are exactly P cycles apart while unpaused.
- **Simultaneous events:**
  - `restart` has priority over `clr_valid`.
  - `clr_valid` is accepted while `pause`=1.
  - `restart` during SHIFT returns the FSM to IDLE with `score_bcd`=0.
- **Mid-operation reset:** rstn asserted at any point clears all state asynchronously, with no partial update.

## Test plan
- **Point values:** reset, then clr_valid with count=1, 2, 3, 4 in sequence → score 1, 11, 77, 177; lines 10; level 1.
- **Saturation:** score=950, clr count=4 → score=999, target_reached=1; a further clr count=1 → score 999 and lines unchanged.
- **Invalid counts:** clr_count=0 and clr_count=6 with clr_valid → no change to any output.
- **Level and timer:** use small test parameters TICK_BASE=20, TICK_STEP=5, TICK_MIN=8 and LINES_PER_LEVEL=4.
  - Ticks are 20 cycles apart at level 0.
  - After 4 lines, ticks are 15 apart.
  - At level 3, the period clamps to 8.
  - 6 cycles of pause delay the next tick by exactly 6 cycles.
- **BCD conversion:** score 0→177 → bcd_valid low for SCORE_W+1 cycles, then score_bcd=16'h0177. A second clear during SHIFT restarts the conversion, and the final score_bcd matches the final score.
- **Restart and reset:** restart asserted in the same cycle as clr_valid → all outputs 0, bcd_valid=1. rstn pulsed mid-SHIFT → same result.
